multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum number of mem_ready-low wait cycles; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port op, input, 7, instr[6:0].
REQ-005 SHALL have port funct3, input, 3, instr[14:12].
REQ-006 SHALL have port funct7b5, input, 1, instr[30].
REQ-007 SHALL have port zero, input, 1, ALU zero flag.
REQ-008 SHALL have port mem_ready, input, 1, memory completes the current access.
REQ-009 SHALL have outputs pc_write, ir_write, reg_write, mem_req, mem_write, adr_src, illegal, bus_err, each 1 bit.
REQ-010 SHALL have outputs imm_src[1:0] (to sign extender), alu_src_a[1:0], alu_src_b[1:0], result_src[1:0] and alu_control[2:0].

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL and TRAP.
REQ-012 SHALL drive every output to 0 unless this section lists it for the current state.
REQ-013 FETCH: mem_req=1, alu_src_a=00, alu_src_b=10, alu_control=000, result_src=10; ir_write=pc_write=mem_ready; stay in FETCH until mem_ready=1, then go to DECODE.
REQ-014 DECODE: alu_src_a=01, alu_src_b=01, alu_control=000, imm_src=10.
REQ-015 DECODE transitions: op 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 with funct3 000/001 -> BRANCH; any other op or funct3 -> TRAP.
REQ-016 MEMADR: alu_src_a=10, alu_src_b=01; imm_src=00 for a load, 01 for a store; next state MEMREAD for a load, MEMWRITE for a store.
REQ-017 MEMREAD: mem_req=1, adr_src=1; go to MEMWB on mem_ready. MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-018 MEMWRITE: mem_req=1, mem_write=1, adr_src=1; go to FETCH on mem_ready.
REQ-019 EXECR: alu_src_a=10, alu_src_b=00. EXECI: alu_src_a=10, alu_src_b=01, imm_src=00. Both go to ALUWB.
REQ-020 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-021 alu_control in EXECR/EXECI, by funct3:
- 000: ADD (000); SUB (001) only in EXECR with funct7b5=1
- 010: SLT (101)
- 110: OR (011)
- 111: AND (010)
- other: ADD
REQ-022 BRANCH: alu_src_a=10, alu_src_b=00, alu_control=001, result_src=00; pc_write=zero for funct3 000, pc_write=~zero for 001; next state FETCH.
REQ-023 TRAP: illegal=1; all other outputs except bus_err are 0; TRAP is held until rst.
REQ-024 SHALL keep a wait counter, incremented each cycle in FETCH/MEMREAD/MEMWRITE while mem_ready=0 and cleared on any state change.
REQ-025 When the counter reaches MEM_TIMEOUT (nonzero), the FSM SHALL go to TRAP with bus_err=1, sticky.
REQ-026 mem_ready=1 in the same cycle the counter reaches the limit SHALL complete the access normally, with no trap.
REQ-027 mem_ready SHALL be ignored outside FETCH/MEMREAD/MEMWRITE.

Reset
REQ-028 While rst=1, every output SHALL be 0.
REQ-029 On a clock edge with rst=1: state <= FETCH, counter <= 0, illegal and bus_err cleared.
REQ-030 Reset mid-access (any state, including TRAP) SHALL abandon the access with no pc_write, reg_write or mem_write in that cycle.
REQ-031 The first cycle after rst deasserts SHALL be FETCH.

Configuration
REQ-032 Macro MULTICYCLE_CTRL_JAL_EN SHALL enable JAL support.
REQ-033 With the macro defined, op 1101111 SHALL select:
- DECODE: imm_src=11
- DECODE -> JAL
- JAL: alu_src_a=01, alu_src_b=10, alu_control=000, result_src=00, pc_write=1; next state ALUWB, writing PC+4 to rd
REQ-034 Without the macro, op 1101111 SHALL go DECODE -> TRAP, and imm_src SHALL never be 11.

Verification
REQ-035 Load, mem_ready delayed 3 cycles in FETCH: sequence FETCH x4, DECODE, MEMADR(imm_src=00), MEMREAD, MEMWB(reg_write=1, result_src=01), FETCH; ir_write only in the 4th FETCH cycle.
REQ-036 R-type op=0110011, funct3=000, funct7b5=1: EXECR alu_control=001, then ALUWB reg_write=1; 4 cycles total with instant mem_ready.
REQ-037 Branch op=1100011: funct3=000 with zero=1 gives pc_write=1 in BRANCH; funct3=001 with zero=1 gives pc_write=0.
REQ-038 op=0000000 -> TRAP, illegal=1 held for 10 cycles with all writes 0; rst pulse returns to FETCH with illegal=0.
REQ-039 MEM_TIMEOUT=4, mem_ready held 0 in MEMWRITE -> TRAP with bus_err=1 after 4 wait cycles; mem_write never asserted afterwards.
REQ-040 op=1101111: with the macro, DECODE imm_src=11, JAL pc_write=1, then ALUWB reg_write=1; without the macro, TRAP.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Main controller of a multicycle RV32 datapath. A Moore FSM steps through
//   FETCH / DECODE / execute / writeback states and drives the datapath
//   selects. Memory accesses wait on mem_ready. A wait counter traps a
//   stalled access to TRAP with a sticky bus_err.
//
// Parameters
//   MEM_TIMEOUT  maximum mem_ready-low wait cycles per access (0 = no limit)
//
// Configuration
//   `define MULTICYCLE_CTRL_JAL_EN  adds JAL support (op 1101111). Without it,
//   JAL decodes as an illegal instruction.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   op/funct3/funct7b5 instruction fields instr[6:0], instr[14:12], instr[30]
//   zero               ALU zero flag (branch condition)
//   mem_ready          memory completes the current access
//   pc_write, ir_write, reg_write, mem_req, mem_write, adr_src
//                      datapath write enables and address select
//   illegal, bus_err   trap status (illegal instruction / memory timeout)
//   imm_src, alu_src_a, alu_src_b, result_src, alu_control
//                      datapath multiplexer and ALU controls
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       illegal,
    output logic       bus_err,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MULTICYCLE_CTRL_JAL_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

    localparam bit          TMO_EN = (MEM_TIMEOUT != 0);
    localparam int unsigned CW     = TMO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    // Outputs that depend only on the state; registered alongside it.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic       illegal;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result;
        logic [2:0] alu;
    } moore_t;

    state_t        state, nxt;
    moore_t        mo_q;
    logic [CW-1:0] wait_cnt;
    logic          bus_err_q;
    logic          waiting;
    logic          timeout;

    function automatic moore_t moore_of(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            FETCH:    begin m.mem_req = 1'b1; m.src_b = 2'b10; m.result = 2'b10; end
            DECODE:   begin m.src_a = 2'b01; m.src_b = 2'b01; end
            MEMADR:   begin m.src_a = 2'b10; m.src_b = 2'b01; end
            MEMREAD:  begin m.mem_req = 1'b1; m.adr_src = 1'b1; end
            MEMWB:    begin m.result = 2'b01; m.reg_write = 1'b1; end
            MEMWRITE: begin m.mem_req = 1'b1; m.mem_write = 1'b1; m.adr_src = 1'b1; end
            EXECR:    begin m.src_a = 2'b10; m.src_b = 2'b00; end
            EXECI:    begin m.src_a = 2'b10; m.src_b = 2'b01; end
            ALUWB:    m.reg_write = 1'b1;
            BRANCH:   begin m.src_a = 2'b10; m.src_b = 2'b00; m.alu = 3'b001; end
            JAL:      begin m.src_a = 2'b01; m.src_b = 2'b10; end
            TRAP:     m.illegal = 1'b1;
            default:  ;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] alu_exec(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:  return sub_en ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // The counter holds the number of low cycles already spent in this state.
    // Once it equals MEM_TIMEOUT the limit is used up: ready in that cycle
    // still completes, another low cycle traps.
    always_comb begin
        waiting = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
        timeout = TMO_EN && waiting && !mem_ready && (wait_cnt == LIMIT);
        nxt     = state;
        case (state)
            FETCH:    nxt = mem_ready ? DECODE : (timeout ? TRAP : FETCH);
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt = MEMADR;
                    OP_RTYPE:          nxt = EXECR;
                    OP_ITYPE:          nxt = EXECI;
                    OP_BRANCH:         nxt = (funct3 == 3'b000 || funct3 == 3'b001) ? BRANCH : TRAP;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:            nxt = JAL;
`endif
                    default:           nxt = TRAP;
                endcase
            end
            MEMADR:   nxt = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = mem_ready ? MEMWB : (timeout ? TRAP : MEMREAD);
            MEMWB:    nxt = FETCH;
            MEMWRITE: nxt = mem_ready ? FETCH : (timeout ? TRAP : MEMWRITE);
            EXECR:    nxt = ALUWB;
            EXECI:    nxt = ALUWB;
            ALUWB:    nxt = FETCH;
            BRANCH:   nxt = FETCH;
            JAL:      nxt = ALUWB;
            TRAP:     nxt = TRAP;
            default:  nxt = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            mo_q      <= moore_of(FETCH);
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state <= nxt;
            mo_q  <= moore_of(nxt);
            if (timeout)
                bus_err_q <= 1'b1;
            if (nxt != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready && wait_cnt != '1)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Input-qualified outputs (handshake, branch condition, decode of the
    // held instruction) are combined here; rst forces everything low so an
    // access interrupted by reset never writes.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = mo_q.reg_write;
        mem_req     = mo_q.mem_req;
        mem_write   = mo_q.mem_write;
        adr_src     = mo_q.adr_src;
        illegal     = mo_q.illegal;
        bus_err     = bus_err_q;
        imm_src     = 2'b00;
        alu_src_a   = mo_q.src_a;
        alu_src_b   = mo_q.src_b;
        result_src  = mo_q.result;
        alu_control = mo_q.alu;
        case (state)
            FETCH: begin
                pc_write = mem_ready;
                ir_write = mem_ready;
            end
            DECODE: begin
                imm_src = 2'b10;
`ifdef MULTICYCLE_CTRL_JAL_EN
                if (op == OP_JAL)
                    imm_src = 2'b11;
`endif
            end
            MEMADR:  imm_src = (op == OP_STORE) ? 2'b01 : 2'b00;
            EXECR:   alu_control = alu_exec(funct3, funct7b5);
            EXECI:   alu_control = alu_exec(funct3, 1'b0);
            BRANCH:  pc_write = funct3[0] ? ~zero : zero;
            JAL:     pc_write = 1'b1;
            default: ;
        endcase
        if (rst) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            adr_src     = 1'b0;
            illegal     = 1'b0;
            bus_err     = 1'b0;
            imm_src     = '0;
            alu_src_a   = '0;
            alu_src_b   = '0;
            result_src  = '0;
            alu_control = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4). A directed
//   table of per-cycle vectors covers the corner sequences; a randomized
//   instruction stream is then expanded by an instruction-level model into
//   expected per-cycle outputs. Honours `define MULTICYCLE_CTRL_JAL_EN.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int unsigned TMO = 4;
`ifdef MULTICYCLE_CTRL_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       illegal;
        logic       bus_err;
        logic [1:0] imm_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } outv_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       rdy;
        outv_t      exp;
        string      tag;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, reg_write, mem_req, mem_write, adr_src, illegal, bus_err;
    logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control;

    int checks = 0;
    int failures = 0;
    int row_no = 0;

    cyc_t iq[$];
    cyc_t vec[$];

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic       cur_zero;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .illegal(illegal), .bus_err(bus_err), .imm_src(imm_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control)
    );

    always #5 clk = ~clk;

    // Expected outputs of each controller step, straight from the output table.
    function automatic outv_t o_none();
        outv_t o = '0;
        return o;
    endfunction
    function automatic outv_t o_fetch(input logic rdy);
        outv_t o = '0;
        o.mem_req = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic outv_t o_decode(input logic [6:0] opc);
        outv_t o = '0;
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b01;
        o.imm_src = (JAL_EN && opc == OP_JAL) ? 2'b11 : 2'b10;
        return o;
    endfunction
    function automatic outv_t o_memadr(input logic store);
        outv_t o = '0;
        o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.imm_src = store ? 2'b01 : 2'b00;
        return o;
    endfunction
    function automatic outv_t o_memread();
        outv_t o = '0;
        o.mem_req = 1'b1; o.adr_src = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_memwb();
        outv_t o = '0;
        o.result_src = 2'b01; o.reg_write = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_memwrite();
        outv_t o = '0;
        o.mem_req = 1'b1; o.mem_write = 1'b1; o.adr_src = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_exec(input logic is_r, input logic [2:0] alu);
        outv_t o = '0;
        o.alu_src_a = 2'b10; o.alu_src_b = is_r ? 2'b00 : 2'b01; o.alu_control = alu;
        return o;
    endfunction
    function automatic outv_t o_aluwb();
        outv_t o = '0;
        o.reg_write = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_branch(input logic pcw);
        outv_t o = '0;
        o.alu_src_a = 2'b10; o.alu_control = 3'b001; o.pc_write = pcw;
        return o;
    endfunction
    function automatic outv_t o_jal();
        outv_t o = '0;
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1;
        return o;
    endfunction
    function automatic outv_t o_trap(input logic be);
        outv_t o = '0;
        o.illegal = 1'b1; o.bus_err = be;
        return o;
    endfunction

    function automatic logic [2:0] alu_expect(input logic [2:0] f3, input logic f7, input logic is_r);
        if (f3 == 3'b000) return (is_r && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_zero = z;
    endtask

    task automatic row(input logic r, input logic rdy, input outv_t e, input string t);
        cyc_t c;
        c.rst = r; c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7; c.zero = cur_zero;
        c.rdy = rdy; c.exp = e; c.tag = t;
        iq.push_back(c);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Access that sees mem_ready after d low cycles; more than TMO lows trap.
    task automatic wait_access(input int d, input outv_t lo, input outv_t hi, input string t,
                               output logic trapped);
        trapped = 1'b0;
        for (int i = 0; i <= int'(TMO); i++) begin
            if (i == d) begin
                row(1'b0, 1'b1, hi, t);
                return;
            end
            row(1'b0, 1'b0, lo, t);
        end
        trapped = 1'b1;
    endtask

    task automatic trap_tail(input logic be, input int n);
        for (int i = 0; i < n; i++) row(1'b0, rbit(), o_trap(be), be ? "trap_bus" : "trap_ill");
        row(1'b1, rbit(), o_none(), "trap_reset");
    endtask

    // Instruction-level model: expands one instruction into expected cycles.
    task automatic gen_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fd, input int md);
        logic tr;
        set_instr(o, f3, f7, z);
        wait_access(fd, o_fetch(1'b0), o_fetch(1'b1), "m_fetch", tr);
        if (tr) begin
            trap_tail(1'b1, 3);
            return;
        end
        row(1'b0, rbit(), o_decode(o), "m_decode");
        if (o == OP_LD || o == OP_ST) begin
            row(1'b0, rbit(), o_memadr(o == OP_ST), "m_memadr");
            if (o == OP_LD) begin
                wait_access(md, o_memread(), o_memread(), "m_memread", tr);
                if (!tr) row(1'b0, rbit(), o_memwb(), "m_memwb");
            end else begin
                wait_access(md, o_memwrite(), o_memwrite(), "m_memwrite", tr);
            end
            if (tr) trap_tail(1'b1, 3);
        end else if (o == OP_R || o == OP_I) begin
            row(1'b0, rbit(), o_exec(o == OP_R, alu_expect(f3, f7, o == OP_R)), "m_exec");
            row(1'b0, rbit(), o_aluwb(), "m_aluwb");
        end else if (o == OP_BR && f3[2:1] == 2'b00) begin
            row(1'b0, rbit(), o_branch(f3[0] ? !z : z), "m_branch");
        end else if (JAL_EN && o == OP_JAL) begin
            row(1'b0, rbit(), o_jal(), "m_jal");
            row(1'b0, rbit(), o_aluwb(), "m_aluwb");
        end else begin
            trap_tail(1'b0, 3);
        end
    endtask

    task automatic apply(input cyc_t c);
        outv_t got;
        @(posedge clk);
        #1;
        rst = c.rst; op = c.op; funct3 = c.f3; funct7b5 = c.f7; zero = c.zero; mem_ready = c.rdy;
        @(negedge clk);
        got.pc_write = pc_write;     got.ir_write = ir_write;   got.reg_write = reg_write;
        got.mem_req = mem_req;       got.mem_write = mem_write; got.adr_src = adr_src;
        got.illegal = illegal;       got.bus_err = bus_err;     got.imm_src = imm_src;
        got.alu_src_a = alu_src_a;   got.alu_src_b = alu_src_b; got.result_src = result_src;
        got.alu_control = alu_control;
        checks++;
        if (got !== c.exp) begin
            failures++;
            $display("FAIL %s row=%0d outputs got=%05h expected=%05h", c.tag, row_no, got, c.exp);
        end
        row_no++;
    endtask

    initial begin
        // ---------------- directed vector table ----------------
        set_instr(OP_LD, 3'b010, 1'b0, 1'b0);
        row(1'b1, 1'b0, o_none(), "reset0");
        row(1'b1, 1'b1, o_none(), "reset1");
        for (int i = 0; i < 3; i++) row(1'b0, 1'b0, o_fetch(1'b0), "ld_fetch_wait");
        row(1'b0, 1'b1, o_fetch(1'b1), "ld_fetch4");
        row(1'b0, 1'b0, o_decode(OP_LD), "ld_decode");
        row(1'b0, 1'b1, o_memadr(1'b0), "ld_memadr");
        row(1'b0, 1'b1, o_memread(), "ld_memread");
        row(1'b0, 1'b0, o_memwb(), "ld_memwb");

        set_instr(OP_R, 3'b000, 1'b1, 1'b0);
        row(1'b0, 1'b1, o_fetch(1'b1), "sub_fetch");
        row(1'b0, 1'b1, o_decode(OP_R), "sub_decode");
        row(1'b0, 1'b0, o_exec(1'b1, 3'b001), "sub_execr");
        row(1'b0, 1'b1, o_aluwb(), "sub_aluwb");

        set_instr(OP_R, 3'b110, 1'b1, 1'b0);
        row(1'b0, 1'b1, o_fetch(1'b1), "or_fetch");
        row(1'b0, 1'b0, o_decode(OP_R), "or_decode");
        row(1'b0, 1'b0, o_exec(1'b1, 3'b011), "or_execr");
        row(1'b0, 1'b0, o_aluwb(), "or_aluwb");

        set_instr(OP_I, 3'b000, 1'b1, 1'b0);
        row(1'b0, 1'b1, o_fetch(1'b1), "addi_fetch");
        row(1'b0, 1'b0, o_decode(OP_I), "addi_decode");
        row(1'b0, 1'b0, o_exec(1'b0, 3'b000), "addi_execi");
        row(1'b0, 1'b0, o_aluwb(), "addi_aluwb");

        set_instr(OP_BR, 3'b000, 1'b0, 1'b1);
        row(1'b0, 1'b1, o_fetch(1'b1), "beq_fetch");
        row(1'b0, 1'b0, o_decode(OP_BR), "beq_decode");
        row(1'b0, 1'b0, o_branch(1'b1), "beq_taken");
        set_instr(OP_BR, 3'b001, 1'b0, 1'b1);
        row(1'b0, 1'b1, o_fetch(1'b1), "bne_fetch");
        row(1'b0, 1'b0, o_decode(OP_BR), "bne_decode");
        row(1'b0, 1'b1, o_branch(1'b0), "bne_not_taken");

        set_instr(OP_ST, 3'b010, 1'b0, 1'b0);
        row(1'b0, 1'b1, o_fetch(1'b1), "st_fetch");
        row(1'b0, 1'b1, o_decode(OP_ST), "st_decode");
        row(1'b0, 1'b0, o_memadr(1'b1), "st_memadr");
        for (int i = 0; i < 4; i++) row(1'b0, 1'b0, o_memwrite(), "st_wait");
        row(1'b0, 1'b1, o_memwrite(), "st_ready_at_limit");
        row(1'b0, 1'b1, o_fetch(1'b1), "st_to_fetch");
        row(1'b0, 1'b1, o_decode(OP_ST), "sto_decode");
        row(1'b0, 1'b0, o_memadr(1'b1), "sto_memadr");
        for (int i = 0; i < 5; i++) row(1'b0, 1'b0, o_memwrite(), "sto_wait");
        for (int i = 0; i < 4; i++) row(1'b0, 1'(i), o_trap(1'b1), "sto_trap");
        row(1'b1, 1'b0, o_none(), "sto_reset");

        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        row(1'b0, 1'b1, o_fetch(1'b1), "ill_fetch");
        row(1'b0, 1'b0, o_decode(7'b0000000), "ill_decode");
        for (int i = 0; i < 10; i++) row(1'b0, 1'(i), o_trap(1'b0), "ill_trap");
        row(1'b1, 1'b1, o_none(), "ill_reset");

        set_instr(OP_I, 3'b111, 1'b0, 1'b0);
        row(1'b0, 1'b0, o_fetch(1'b0), "and_fetch_wait");
        row(1'b0, 1'b1, o_fetch(1'b1), "and_fetch");
        row(1'b0, 1'b0, o_decode(OP_I), "and_decode");
        row(1'b0, 1'b0, o_exec(1'b0, 3'b010), "and_execi");
        row(1'b0, 1'b0, o_aluwb(), "and_aluwb");

        set_instr(OP_BR, 3'b100, 1'b0, 1'b1);
        row(1'b0, 1'b1, o_fetch(1'b1), "blt_fetch");
        row(1'b0, 1'b0, o_decode(OP_BR), "blt_decode");
        row(1'b0, 1'b0, o_trap(1'b0), "blt_trap");
        row(1'b1, 1'b0, o_none(), "blt_reset");

        for (int i = 0; i < 5; i++) row(1'b0, 1'b0, o_fetch(1'b0), "fto_wait");
        row(1'b0, 1'b1, o_trap(1'b1), "fto_trap");
        row(1'b1, 1'b0, o_none(), "fto_reset");

        set_instr(OP_BR, 3'b000, 1'b0, 1'b1);
        row(1'b0, 1'b1, o_fetch(1'b1), "rbr_fetch");
        row(1'b0, 1'b0, o_decode(OP_BR), "rbr_decode");
        row(1'b1, 1'b0, o_none(), "rst_in_branch");
        set_instr(OP_ST, 3'b010, 1'b0, 1'b0);
        row(1'b0, 1'b1, o_fetch(1'b1), "rst_fetch");
        row(1'b0, 1'b0, o_decode(OP_ST), "rst_decode");
        row(1'b0, 1'b0, o_memadr(1'b1), "rst_memadr");
        row(1'b1, 1'b1, o_none(), "rst_in_memwrite");
        row(1'b1, 1'b1, o_none(), "rst_in_fetch");

        set_instr(OP_JAL, 3'b000, 1'b0, 1'b0);
        row(1'b0, 1'b1, o_fetch(1'b1), "jal_fetch");
        row(1'b0, 1'b0, o_decode(OP_JAL), "jal_decode");
        if (JAL_EN) begin
            row(1'b0, 1'b0, o_jal(), "jal_jal");
            row(1'b0, 1'b0, o_aluwb(), "jal_aluwb");
        end else begin
            row(1'b0, 1'b0, o_trap(1'b0), "jal_trap");
            row(1'b0, 1'b1, o_trap(1'b0), "jal_trap");
            row(1'b1, 1'b0, o_none(), "jal_reset");
        end

        vec = iq;
        iq.delete();
        foreach (vec[i]) apply(vec[i]);

        // ---------------- randomized instruction stream ----------------
        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            logic [2:0] f3;
            int fd, md;
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: o = OP_LD;
                1: o = OP_ST;
                2: o = OP_R;
                3: o = OP_I;
                4, 7: begin
                    o = OP_BR;
                    if (rbit()) f3 = {2'b00, rbit()};
                end
                5: o = OP_JAL;
                default: o = 7'($urandom_range(0, 127));
            endcase
            fd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1));
            md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1));
            gen_instr(o, f3, rbit(), rbit(), fd, md);
            // Occasionally cut the instruction short with a reset.
            if ($urandom_range(0, 11) == 0) begin
                int k;
                k = int'($urandom_range(0, iq.size() - 1));
                while (iq.size() > k + 1) void'(iq.pop_back());
                iq[k].rst = 1'b1;
                iq[k].exp = o_none();
                iq[k].tag = "rnd_rst_mid";
            end
            foreach (iq[i]) apply(iq[i]);
            iq.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
